// File: rtl/conv_feeder_pkg.sv
// Shared constants and state type for the convolution window feeder.
package conv_feeder_pkg;

    localparam int unsigned OUT_BASE_W    = 13;
    localparam int unsigned SUM_W         = OUT_BASE_W + 4;
    localparam int unsigned SEQ_OFFSET    = 11;
    localparam int unsigned IDLE_COE_ADDR = 7;
    localparam int unsigned RND_CONST     = 8;
    localparam int unsigned RND_SHIFT     = 4;
    localparam int unsigned SAT_LIMIT     = 255;
    localparam int unsigned WIN_LAST      = 15;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_FETCH,
        ST_DRAIN,
        ST_CAPTURE,
        ST_OUT
    } state_t;

endpackage

// File: rtl/conv_sobel_postproc.sv
// Post-processing of one accumulated sum into an 8-bit result.
//   i_sum   : two's-complement accumulator sum
//   i_mode  : 1 = sobel (|s| saturated), 0 = conv ((s+8)>>>4 clamped to 0..255)
//   o_res_c : combinational result
module conv_sobel_postproc
    import conv_feeder_pkg::*;
#(
    parameter int unsigned IN_W  = SUM_W,
    parameter int unsigned OUT_W = 8
) (
    input  logic [IN_W-1:0]  i_sum,
    input  logic             i_mode,
    output logic [OUT_W-1:0] o_res_c
);

    // One extra bit so that +8 and negation of the most negative sum cannot overflow.
    logic signed [IN_W:0] sum_x;
    logic signed [IN_W:0] rnd;
    logic signed [IN_W:0] shf;
    logic signed [IN_W:0] mag;
    logic signed [IN_W:0] val;

    always_comb begin
        sum_x = $signed({i_sum[IN_W-1], i_sum});
        rnd   = sum_x + $signed((IN_W+1)'(RND_CONST));
        shf   = rnd >>> RND_SHIFT;
        mag   = sum_x[IN_W] ? -sum_x : sum_x;
        val   = i_mode ? mag : shf;
        if (val[IN_W]) begin
            o_res_c = '0;
        end else if (val > $signed((IN_W+1)'(SAT_LIMIT))) begin
            o_res_c = OUT_W'(SAT_LIMIT);
        end else begin
            o_res_c = val[OUT_W-1:0];
        end
    end

endmodule

// File: rtl/conv_window_feeder.sv
// Walks a 4x4 window of the image SRAM, streams pixels with coefficient
// mode/address and clear into the 2x2 accumulator, then captures and
// post-processes the four sums onto a valid/ready result port.
//   i_clk, i_rst          : clock, synchronous active-high reset
//   i_start/i_mode/i_org_*: job request, mode and signed window origin
//   o_busy                : high outside IDLE
//   o_sram_cen/addr, i_sram_data : SRAM read port (1-cycle latency)
//   o_pix_data, o_coe_mode_addr, o_clear : accumulator feed
//   i_sum_*               : accumulator sums
//   o_valid/i_ready/o_res_* : result handshake
module conv_window_feeder
    import conv_feeder_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned OUT_DATA_W = OUT_BASE_W,
    parameter int unsigned IMG_W      = 8,
    parameter int unsigned ADDR_W     = 6
) (
    input  logic                    i_clk,
    input  logic                    i_rst,
    input  logic                    i_start,
    input  logic                    i_mode,
    input  logic [3:0]              i_org_row,
    input  logic [3:0]              i_org_col,
    output logic                    o_busy,
    output logic                    o_sram_cen,
    output logic [ADDR_W-1:0]       o_sram_addr,
    input  logic [DATA_WIDTH-1:0]   i_sram_data,
    output logic [DATA_WIDTH-1:0]   o_pix_data,
    output logic [4:0]              o_coe_mode_addr,
    output logic                    o_clear,
    input  logic [OUT_DATA_W+3:0]   i_sum_ul,
    input  logic [OUT_DATA_W+3:0]   i_sum_ur,
    input  logic [OUT_DATA_W+3:0]   i_sum_ll,
    input  logic [OUT_DATA_W+3:0]   i_sum_lr,
    output logic                    o_valid,
    input  logic                    i_ready,
    output logic [DATA_WIDTH-1:0]   o_res_ul,
    output logic [DATA_WIDTH-1:0]   o_res_ur,
    output logic [DATA_WIDTH-1:0]   o_res_ll,
    output logic [DATA_WIDTH-1:0]   o_res_lr
);

    localparam int unsigned LOG_W   = $clog2(IMG_W);
    localparam int unsigned COORD_W = 6;

    state_t          state, state_n;
    logic [3:0]      k, k_n;
    logic            mode_q;
    logic [3:0]      org_row_q, org_col_q;
    logic            al_vld, al_vld_n;
    logic            al_pad;
    logic            latch, capture, issue;
    logic            busy_n, valid_n, clear_n;
    logic [4:0]      coe_n;
    logic [3:0]      iss_k, iss_org_r, iss_org_c;
    logic [COORD_W-1:0] iss_row, iss_col;
    logic            iss_pad;
    logic [ADDR_W-1:0] iss_addr;
    logic [DATA_WIDTH-1:0] pp_ul, pp_ur, pp_ll, pp_lr;

    // Next state and next registered-output values.
    always_comb begin
        state_n   = state;
        k_n       = k;
        latch     = 1'b0;
        capture   = 1'b0;
        issue     = 1'b0;
        iss_k     = k + 4'd1;
        iss_org_r = org_row_q;
        iss_org_c = org_col_q;
        busy_n    = 1'b1;
        valid_n   = 1'b0;
        clear_n   = 1'b0;
        al_vld_n  = 1'b0;
        coe_n     = {mode_q, 4'(IDLE_COE_ADDR)};
        case (state)
            ST_IDLE: begin
                busy_n  = 1'b0;
                clear_n = 1'b1;
                if (i_start) begin
                    state_n   = ST_FETCH;
                    k_n       = '0;
                    latch     = 1'b1;
                    busy_n    = 1'b1;
                    issue     = 1'b1;
                    iss_k     = '0;
                    iss_org_r = i_org_row;
                    iss_org_c = i_org_col;
                end
            end
            ST_FETCH: begin
                // Coefficient address for the pixel whose read data lands next cycle.
                al_vld_n = 1'b1;
                coe_n    = {mode_q, k + 4'(SEQ_OFFSET)};
                if (k == 4'(WIN_LAST)) begin
                    state_n = ST_DRAIN;
                end else begin
                    k_n   = k + 4'd1;
                    issue = 1'b1;
                end
            end
            ST_DRAIN: begin
                state_n = ST_CAPTURE;
            end
            ST_CAPTURE: begin
                state_n = ST_OUT;
                valid_n = 1'b1;
                clear_n = 1'b1;
                capture = 1'b1;
            end
            ST_OUT: begin
                clear_n = 1'b1;
                valid_n = 1'b1;
                if (i_ready) begin
                    state_n = ST_IDLE;
                    valid_n = 1'b0;
                    busy_n  = 1'b0;
                end
            end
            default: begin
                state_n = ST_IDLE;
            end
        endcase
    end

    // Pixel coordinate of the read being issued; negative values wrap high and fail the range test.
    always_comb begin
        iss_row  = {{(COORD_W-4){iss_org_r[3]}}, iss_org_r} + COORD_W'(iss_k[3:2]);
        iss_col  = {{(COORD_W-4){iss_org_c[3]}}, iss_org_c} + COORD_W'(iss_k[1:0]);
        iss_pad  = (iss_row >= COORD_W'(IMG_W)) || (iss_col >= COORD_W'(IMG_W));
        iss_addr = ADDR_W'({iss_row[LOG_W-1:0], iss_col[LOG_W-1:0]});
    end

    // State register.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= ST_IDLE;
            k     <= '0;
        end else begin
            state <= state_n;
            k     <= k_n;
        end
    end

    // Job context, read-data alignment and registered outputs.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            mode_q          <= 1'b0;
            org_row_q       <= '0;
            org_col_q       <= '0;
            al_vld          <= 1'b0;
            al_pad          <= 1'b1;
            o_busy          <= 1'b0;
            o_valid         <= 1'b0;
            o_clear         <= 1'b1;
            o_sram_cen      <= 1'b1;
            o_sram_addr     <= '0;
            o_coe_mode_addr <= '0;
            o_res_ul        <= '0;
            o_res_ur        <= '0;
            o_res_ll        <= '0;
            o_res_lr        <= '0;
        end else begin
            if (latch) begin
                mode_q    <= i_mode;
                org_row_q <= i_org_row;
                org_col_q <= i_org_col;
            end
            al_vld          <= al_vld_n;
            // A suppressed read is exactly a padded cell.
            al_pad          <= o_sram_cen;
            o_busy          <= busy_n;
            o_valid         <= valid_n;
            o_clear         <= clear_n;
            o_coe_mode_addr <= coe_n;
            if (issue) begin
                o_sram_cen <= iss_pad;
                if (!iss_pad) begin
                    o_sram_addr <= iss_addr;
                end
            end else begin
                o_sram_cen <= 1'b1;
            end
            if (capture) begin
                o_res_ul <= pp_ul;
                o_res_ur <= pp_ur;
                o_res_ll <= pp_ll;
                o_res_lr <= pp_lr;
            end
        end
    end

    assign o_pix_data = (al_vld && !al_pad) ? i_sram_data : '0;

    conv_sobel_postproc #(.IN_W(OUT_DATA_W + 4), .OUT_W(DATA_WIDTH)) u_pp_ul (
        .i_sum(i_sum_ul), .i_mode(mode_q), .o_res_c(pp_ul)
    );
    conv_sobel_postproc #(.IN_W(OUT_DATA_W + 4), .OUT_W(DATA_WIDTH)) u_pp_ur (
        .i_sum(i_sum_ur), .i_mode(mode_q), .o_res_c(pp_ur)
    );
    conv_sobel_postproc #(.IN_W(OUT_DATA_W + 4), .OUT_W(DATA_WIDTH)) u_pp_ll (
        .i_sum(i_sum_ll), .i_mode(mode_q), .o_res_c(pp_ll)
    );
    conv_sobel_postproc #(.IN_W(OUT_DATA_W + 4), .OUT_W(DATA_WIDTH)) u_pp_lr (
        .i_sum(i_sum_lr), .i_mode(mode_q), .o_res_c(pp_lr)
    );

endmodule

// File: tb/tb_conv_window_feeder.sv
// Bench for conv_window_feeder: image SRAM model, behavioural 2x2 accumulator,
// direct-convolution reference and a per-cycle compare process.
module tb_conv_window_feeder;

    logic        i_clk = 1'b0;
    logic        i_rst;
    logic        i_start;
    logic        i_mode;
    logic [3:0]  i_org_row;
    logic [3:0]  i_org_col;
    logic        o_busy;
    logic        o_sram_cen;
    logic [5:0]  o_sram_addr;
    logic [7:0]  i_sram_data;
    logic [7:0]  o_pix_data;
    logic [4:0]  o_coe_mode_addr;
    logic        o_clear;
    logic [16:0] i_sum_ul, i_sum_ur, i_sum_ll, i_sum_lr;
    logic        o_valid;
    logic        i_ready;
    logic [7:0]  o_res_ul, o_res_ur, o_res_ll, o_res_lr;

    always #5 i_clk = ~i_clk;

    conv_window_feeder dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_start(i_start), .i_mode(i_mode),
        .i_org_row(i_org_row), .i_org_col(i_org_col), .o_busy(o_busy),
        .o_sram_cen(o_sram_cen), .o_sram_addr(o_sram_addr), .i_sram_data(i_sram_data),
        .o_pix_data(o_pix_data), .o_coe_mode_addr(o_coe_mode_addr), .o_clear(o_clear),
        .i_sum_ul(i_sum_ul), .i_sum_ur(i_sum_ur), .i_sum_ll(i_sum_ll), .i_sum_lr(i_sum_lr),
        .o_valid(o_valid), .i_ready(i_ready),
        .o_res_ul(o_res_ul), .o_res_ur(o_res_ur), .o_res_ll(o_res_ll), .o_res_lr(o_res_lr)
    );

    logic [7:0] img [64];
    int  acc [4] = '{0, 0, 0, 0};
    int  checks = 0;
    int  errors = 0;
    bit  chk_en = 1'b0;
    bit  m_active = 1'b0;
    int  m_n = 0;
    bit  job_mode = 1'b0;
    int  job_row = 0;
    int  job_col = 0;
    int  m_res [4];
    int  coe_seq [$];
    int  rd_cnt = 0;
    int  got [4];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Gaussian 1-2-1 separable kernel (sum 16) and Sobel Gx (right minus left).
    function automatic int wgt(input bit sob, input int r, input int c);
        if (r < 0 || r > 2 || c < 0 || c > 2) return 0;
        if (!sob) return ((r == 1) ? 2 : 1) * ((c == 1) ? 2 : 1);
        return (c - 1) * ((r == 1) ? 2 : 1);
    endfunction

    function automatic int pixel(input int r, input int c);
        if (r < 0 || r > 7 || c < 0 || c > 7) return 0;
        return int'(img[r*8 + c]);
    endfunction

    function automatic int model_sum(input bit sob, input int orow, input int ocol, input int q);
        int s;
        s = 0;
        for (int r = 0; r < 3; r++)
            for (int c = 0; c < 3; c++)
                s += pixel(orow + q/2 + r, ocol + q%2 + c) * wgt(sob, r, c);
        return s;
    endfunction

    function automatic int post(input bit sob, input int s);
        int v;
        if (sob) v = (s < 0) ? -s : s;
        else     v = (s + 8) >>> 4;
        if (v < 0)   v = 0;
        if (v > 255) v = 255;
        return v;
    endfunction

    function automatic int res_of(input int q);
        case (q)
            0:       return int'(o_res_ul);
            1:       return int'(o_res_ur);
            2:       return int'(o_res_ll);
            default: return int'(o_res_lr);
        endcase
    endfunction

    // SRAM: one-cycle read latency; junk when no read so padding must mask it.
    always @(posedge i_clk)
        i_sram_data <= (!o_sram_cen) ? img[o_sram_addr] : 8'hA5;

    // Accumulator: coefficient address a selects window cell (a - 11) mod 16.
    always @(posedge i_clk) begin : acc_blk
        int k;
        k = (int'(o_coe_mode_addr[3:0]) + 5) % 16;
        for (int q = 0; q < 4; q++) begin
            if (o_clear) acc[q] <= 0;
            else acc[q] <= acc[q] + int'(o_pix_data) * wgt(o_coe_mode_addr[4], k/4 - q/2, k%4 - q%2);
        end
    end
    assign i_sum_ul = 17'(acc[0]);
    assign i_sum_ur = 17'(acc[1]);
    assign i_sum_ll = 17'(acc[2]);
    assign i_sum_lr = 17'(acc[3]);

    // Reference job timeline: m_n counts edges since acceptance; results due from 18 on.
    always @(posedge i_clk) begin
        if (i_rst) begin
            m_active = 1'b0;
            m_n      = 0;
        end else if (!m_active) begin
            if (i_start) begin
                m_active = 1'b1;
                m_n      = 0;
                job_mode = i_mode;
                job_row  = $signed(i_org_row);
                job_col  = $signed(i_org_col);
                for (int q = 0; q < 4; q++)
                    m_res[q] = post(job_mode, model_sum(job_mode, job_row, job_col, q));
            end
        end else if (m_n >= 18 && i_ready) begin
            m_active = 1'b0;
        end else if (m_n < 18) begin
            m_n++;
        end
    end

    always @(negedge i_clk) begin : cmp
        int k, pr, pc;
        bit pad;
        if (chk_en && !i_rst) begin
            chk("busy", o_busy, m_active);
            chk("valid", o_valid, (m_active && m_n >= 18));
            chk("clear", o_clear, (!m_active || m_n == 0 || m_n >= 18));
            if (!o_sram_cen) rd_cnt++;
            if (m_active && m_n <= 15) begin
                pr  = job_row + m_n/4;
                pc  = job_col + m_n%4;
                pad = (pr < 0 || pr > 7 || pc < 0 || pc > 7);
                chk("sram_cen", o_sram_cen, pad);
                if (!pad) chk("sram_addr", o_sram_addr, pr*8 + pc);
            end else begin
                chk("sram_cen_quiet", o_sram_cen, 1);
            end
            if (m_active && m_n >= 1 && m_n <= 16) begin
                k  = m_n - 1;
                pr = job_row + k/4;
                pc = job_col + k%4;
                chk("pix_data", o_pix_data, pixel(pr, pc));
                chk("coe_mode_addr", o_coe_mode_addr, job_mode*16 + (k + 11) % 16);
                coe_seq.push_back(int'(o_coe_mode_addr[3:0]));
            end else begin
                chk("pix_quiet", o_pix_data, 0);
                if (m_active) chk("coe_quiet_addr", o_coe_mode_addr[3:0], 7);
            end
            if (m_active && m_n >= 18)
                for (int q = 0; q < 4; q++)
                    chk($sformatf("res%0d", q), res_of(q), m_res[q]);
        end
    end

    task automatic tick;
        @(posedge i_clk);
        #1;
    endtask

    task automatic fill_const(input int v);
        for (int i = 0; i < 64; i++) img[i] = 8'(v);
    endtask

    task automatic fill_cols(input int a, input int b);
        for (int i = 0; i < 64; i++) img[i] = 8'((i % 8 < 4) ? a : b);
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_busy"}, o_busy, 0);
        chk({tag, "_valid"}, o_valid, 0);
        chk({tag, "_clear"}, o_clear, 1);
        chk({tag, "_cen"}, o_sram_cen, 1);
        chk({tag, "_addr"}, o_sram_addr, 0);
        chk({tag, "_pix"}, o_pix_data, 0);
        chk({tag, "_coe"}, o_coe_mode_addr, 0);
        for (int q = 0; q < 4; q++) chk({tag, "_res"}, res_of(q), 0);
    endtask

    task automatic run_job(input bit sob, input int r, input int c, input int hold, input bit pulse);
        int n;
        i_start   = 1'b1;
        i_mode    = sob;
        i_org_row = 4'(r);
        i_org_col = 4'(c);
        i_ready   = 1'b0;
        tick;
        i_start = 1'b0;
        i_mode  = ~sob;
        n = 0;
        while (!o_valid && n < 40) begin
            tick;
            n++;
        end
        chk("valid_latency", n, 18);
        for (int q = 0; q < 4; q++) got[q] = res_of(q);
        for (int i = 0; i < hold; i++) begin
            i_start   = pulse && (i % 2 == 0);
            i_org_row = 4'(-1);
            i_org_col = 4'(5);
            tick;
            chk("hold_valid", o_valid, 1);
            for (int q = 0; q < 4; q++) chk("hold_res", res_of(q), got[q]);
        end
        i_start = 1'b0;
        i_ready = 1'b1;
        tick;
        i_ready = 1'b0;
        chk("post_hs_busy", o_busy, 0);
        chk("post_hs_valid", o_valid, 0);
    endtask

    initial begin
        i_rst = 1'b1; i_start = 1'b0; i_mode = 1'b0;
        i_org_row = '0; i_org_col = '0; i_ready = 1'b0;
        fill_const(0);
        repeat (3) @(posedge i_clk);
        #1;
        check_reset("init");
        i_rst  = 1'b0;
        chk_en = 1'b1;

        // Constant image, conv, interior window.
        fill_const(100);
        coe_seq.delete();
        rd_cnt = 0;
        run_job(1'b0, 2, 2, 0, 1'b0);
        for (int q = 0; q < 4; q++) chk("const_conv", got[q], 100);
        chk("coe_seq_len", coe_seq.size(), 16);
        if (coe_seq.size() == 16) begin
            chk("coe_seq0", coe_seq[0], 11);
            chk("coe_seq4", coe_seq[4], 15);
            chk("coe_seq5", coe_seq[5], 0);
            chk("coe_seq15", coe_seq[15], 10);
        end
        chk("reads_interior", rd_cnt, 16);

        // Conv rounding: ul sum 24 then 23.
        fill_const(0);
        img[9] = 8'd6;
        run_job(1'b0, 0, 0, 0, 1'b0);
        chk("round_24", got[0], 2);
        img[9] = 8'd5; img[1] = 8'd1; img[0] = 8'd1;
        run_job(1'b0, 0, 0, 0, 1'b0);
        chk("round_23", got[0], 1);

        // Sobel step edges and gentle gradient.
        fill_cols(0, 200);
        run_job(1'b1, 0, 2, 0, 1'b0);
        chk("sobel_pos_sat", got[0], 255);
        fill_cols(200, 0);
        run_job(1'b1, 0, 2, 0, 1'b0);
        chk("sobel_neg_sat", got[0], 255);
        fill_cols(10, 20);
        run_job(1'b1, 0, 2, 0, 1'b0);
        chk("sobel_grad", got[0], 40);

        // Zero padding at the top-left corner.
        fill_const(100);
        rd_cnt = 0;
        run_job(1'b0, -1, -1, 0, 1'b0);
        chk("pad_ul", got[0], 56);
        chk("pad_lr", got[3], 100);
        chk("pad_reads", rd_cnt, 9);

        // Backpressure with ignored start pulses, then an immediate new job.
        fill_cols(10, 20);
        run_job(1'b1, 0, 2, 5, 1'b1);
        chk("bp_grad", got[0], 40);
        fill_const(100);
        run_job(1'b0, 2, 2, 0, 1'b0);
        chk("after_bp", got[3], 100);

        // Reset in the middle of the fetch (k = 7).
        i_start = 1'b1; i_mode = 1'b0; i_org_row = 4'd2; i_org_col = 4'd2;
        tick;
        i_start = 1'b0;
        repeat (7) tick;
        chk("k7_busy", o_busy, 1);
        i_rst = 1'b1;
        tick;
        check_reset("mid");
        i_rst = 1'b0;
        run_job(1'b0, 2, 2, 0, 1'b0);
        for (int q = 0; q < 4; q++) chk("after_rst", got[q], 100);

        repeat (3) tick;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, %0d checks %0d errors", checks, errors);
        $fatal(1);
    end

endmodule
